// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core and its memory responder.
package riscv_pkg;

   // Main-decoder opcodes
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   // ALU control class handed from the main decoder to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Data-memory responder states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } mem_state_t;

endpackage

// File: rtl/data_mem_array.sv
// Word-wide storage for the data-memory responder: synchronous write,
// combinational read. Contents are deliberately not reset.
module data_mem_array #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];

   // Store port: one word per clock when enabled
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: accepts lw/sw strobes, completes the
// word access after LATENCY cycles, stalls the datapath meanwhile and flags
// misaligned, out-of-range or read+write requests instead of executing them.
module data_memory_responder
   import riscv_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Stall,
   output logic        AddrFault
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   mem_state_t    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic          fault_q, fault_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          ready_q, ready_d;
   logic          afault_q, afault_d;

   logic          req_s;
   logic          fault_s;
   logic          stall_s;
   logic          enter_done_s;
   logic          pend_rd_s;
   logic          pend_fault_s;
   logic [AW-1:0] pend_idx_s;
   logic [31:0]   arr_rdata_s;
   logic          arr_we_s;

   assign req_s   = MemRead | MemWrite;
   assign fault_s = (Address[1:0] != 2'b00)
                 || (Address[31:2] >= 30'(DEPTH))
                 || (MemRead && MemWrite);

   // Request being completed: live inputs when LATENCY=1 jumps straight from IDLE
   always_comb begin
      if (state_q == ST_IDLE) begin
         pend_rd_s    = MemRead;
         pend_fault_s = fault_s;
         pend_idx_s   = Address[2 +: AW];
      end else begin
         pend_rd_s    = rd_q;
         pend_fault_s = fault_q;
         pend_idx_s   = addr_q;
      end
   end

   // Next-state, request latching and completion results
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      fault_d      = fault_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      ready_d      = 1'b0;
      afault_d     = 1'b0;
      stall_s      = 1'b0;
      enter_done_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               stall_s = 1'b1;
               rd_d    = MemRead;
               wr_d    = MemWrite;
               fault_d = fault_s;
               addr_d  = Address[2 +: AW];
               wdata_d = WriteData;
               if (LATENCY == 1) begin
                  enter_done_s = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end else begin
               stall_s = 1'b0;
            end
         end
         ST_WAIT: begin
            stall_s = 1'b1;
            if (cnt_q == 4'd0) begin
               enter_done_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Results are registered on the edge entering DONE so they show in DONE
      if (enter_done_s) begin
         state_d  = ST_DONE;
         ready_d  = 1'b1;
         afault_d = pend_fault_s;
         if (pend_fault_s) begin
            rdata_d = 32'd0;
         end else if (pend_rd_s) begin
            rdata_d = arr_rdata_s;
         end else begin
            rdata_d = rdata_q;
         end
      end else begin
         ready_d  = 1'b0;
         afault_d = 1'b0;
      end
   end

   // State and output registers; reset aborts any pending request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         fault_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         ready_q  <= 1'b0;
         afault_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         fault_q  <= fault_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         afault_q <= afault_d;
      end
   end

   // Store commits at the edge ending DONE, only for a clean store
   assign arr_we_s = (state_q == ST_DONE) && wr_q && !fault_q;

   data_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (arr_we_s),
      .waddr (addr_q),
      .wdata (wdata_q),
      .raddr (pend_idx_s),
      .rdata (arr_rdata_s)
   );

   assign ReadData  = rdata_q;
   assign Ready     = ready_q;
   assign AddrFault = afault_q;
   assign Stall     = stall_s & ~reset;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench: one responder with LATENCY=2 and one with
// LATENCY=1, driven with hand-computed request/response vectors.
module tb_data_memory_responder;

   logic        clk;
   logic        reset;

   logic        rd2, wr2;
   logic [31:0] addr2, wd2;
   logic [31:0] rdata2;
   logic        ready2, stall2, afault2;

   logic        rd1, wr1;
   logic [31:0] addr1, wd1;
   logic [31:0] rdata1;
   logic        ready1, stall1, afault1;

   int n_chk  = 0;
   int n_pass = 0;

   data_memory_responder #(.DEPTH(256), .LATENCY(2)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (rd2),
      .MemWrite  (wr2),
      .Address   (addr2),
      .WriteData (wd2),
      .ReadData  (rdata2),
      .Ready     (ready2),
      .Stall     (stall2),
      .AddrFault (afault2)
   );

   data_memory_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (rd1),
      .MemWrite  (wr1),
      .Address   (addr1),
      .WriteData (wd1),
      .ReadData  (rdata1),
      .Ready     (ready1),
      .Stall     (stall1),
      .AddrFault (afault1)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
      if (sel == 1) begin
         rd1 = rd; wr1 = wr; addr1 = a; wd1 = d;
      end else begin
         rd2 = rd; wr2 = wr; addr2 = a; wd2 = d;
      end
   endtask

   function automatic logic [31:0] rdata_of(input int sel);
      return (sel == 1) ? rdata1 : rdata2;
   endfunction
   function automatic logic ready_of(input int sel);
      return (sel == 1) ? ready1 : ready2;
   endfunction
   function automatic logic stall_of(input int sel);
      return (sel == 1) ? stall1 : stall2;
   endfunction
   function automatic logic afault_of(input int sel);
      return (sel == 1) ? afault1 : afault2;
   endfunction

   // One request on the selected responder; inputs dropped after acceptance
   task automatic req(input int sel, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic ef, input logic [31:0] erd);
      int lat;
      lat = (sel == 1) ? 1 : 2;
      set_in(sel, rd, wr, a, d);
      #1;
      check("stall_accept", {31'd0, stall_of(sel)}, 32'd1);
      check("ready_accept", {31'd0, ready_of(sel)}, 32'd0);
      step();
      set_in(sel, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int k = 1; k < lat; k++) begin
         #1;
         check("stall_wait", {31'd0, stall_of(sel)}, 32'd1);
         check("ready_wait", {31'd0, ready_of(sel)}, 32'd0);
         step();
      end
      #1;
      check("ready_done",  {31'd0, ready_of(sel)},  32'd1);
      check("fault_done",  {31'd0, afault_of(sel)}, {31'd0, ef});
      check("rdata_done",  rdata_of(sel), erd);
      check("stall_done",  {31'd0, stall_of(sel)},  32'd0);
      step();
      #1;
      check("ready_after", {31'd0, ready_of(sel)},  32'd0);
      check("fault_after", {31'd0, afault_of(sel)}, 32'd0);
      check("stall_after", {31'd0, stall_of(sel)},  32'd0);
   endtask

   initial begin
      reset = 1'b1;
      set_in(1, 1'b0, 1'b0, 32'd0, 32'd0);
      set_in(2, 1'b1, 1'b0, 32'd0, 32'd0);
      #2;
      check("rst_stall",  {31'd0, stall2},  32'd0);
      check("rst_ready",  {31'd0, ready2},  32'd0);
      check("rst_fault",  {31'd0, afault2}, 32'd0);
      check("rst_rdata",  rdata2,           32'd0);
      set_in(2, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      reset = 1'b0;

      // Store then load, LATENCY=2
      req(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
      req(2, 1'b1, 1'b0, 32'h10, 32'd0,        1'b0, 32'hDEADBEEF);

      // LATENCY=1 store then load
      req(1, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0, 32'd0);
      req(1, 1'b1, 1'b0, 32'h0, 32'd0,        1'b0, 32'h12345678);

      // Misaligned load faults, memory intact
      req(2, 1'b1, 1'b0, 32'h13, 32'd0, 1'b1, 32'd0);
      req(2, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);

      // Out-of-range store would alias word 0 if executed
      req(2, 1'b0, 1'b1, 32'h0,   32'hA5A5A5A5, 1'b0, 32'hDEADBEEF);
      req(2, 1'b0, 1'b1, 32'h400, 32'h55555555, 1'b1, 32'd0);
      req(2, 1'b1, 1'b0, 32'h0,   32'd0,        1'b0, 32'hA5A5A5A5);

      // Both strobes high faults, no write
      req(2, 1'b1, 1'b1, 32'h10, 32'h77777777, 1'b1, 32'd0);
      req(2, 1'b1, 1'b0, 32'h10, 32'd0,        1'b0, 32'hDEADBEEF);

      // Back-to-back with MemRead held; address change during WAIT ignored
      set_in(2, 1'b1, 1'b0, 32'h10, 32'd0);
      #1;
      check("b2b_stall_t0", {31'd0, stall2}, 32'd1);
      step();
      addr2 = 32'h0;
      #1;
      check("b2b_stall_t1", {31'd0, stall2}, 32'd1);
      check("b2b_ready_t1", {31'd0, ready2}, 32'd0);
      step();
      #1;
      check("b2b_ready_t2", {31'd0, ready2}, 32'd1);
      check("b2b_rdata_t2", rdata2,          32'hDEADBEEF);
      check("b2b_stall_t2", {31'd0, stall2}, 32'd0);
      step();
      #1;
      check("b2b_ready_t3", {31'd0, ready2}, 32'd0);
      check("b2b_stall_t3", {31'd0, stall2}, 32'd1);
      step();
      #1;
      check("b2b_ready_t4", {31'd0, ready2}, 32'd0);
      step();
      set_in(2, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      check("b2b_ready_t5", {31'd0, ready2}, 32'd1);
      check("b2b_rdata_t5", rdata2,          32'hA5A5A5A5);
      step();
      #1;
      check("b2b_ready_t6", {31'd0, ready2}, 32'd0);
      check("b2b_stall_t6", {31'd0, stall2}, 32'd0);

      // Reset during WAIT discards a store
      req(2, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, 32'hA5A5A5A5);
      set_in(2, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
      #1;
      check("abort_stall_t0", {31'd0, stall2}, 32'd1);
      step();
      set_in(2, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      reset = 1'b1;
      #1;
      check("abort_ready",  {31'd0, ready2},  32'd0);
      check("abort_stall",  {31'd0, stall2},  32'd0);
      check("abort_fault",  {31'd0, afault2}, 32'd0);
      check("abort_rdata",  rdata2,           32'd0);
      step();
      check("abort_ready_r1", {31'd0, ready2}, 32'd0);
      step();
      reset = 1'b0;
      #1;
      check("abort_ready_r2", {31'd0, ready2}, 32'd0);
      step();
      #1;
      check("abort_ready_r3", {31'd0, ready2}, 32'd0);
      check("abort_stall_r3", {31'd0, stall2}, 32'd0);
      req(2, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'h11111111);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
